// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder/subtractor.
package adder_pkg;

  localparam int BLOCK_MAX = 8;

  typedef struct packed {
    logic [BLOCK_MAX-1:0] sum;
    logic                 p;
    logic                 g;
  } cla_grp_t;

  // One lookahead group of n (<= BLOCK_MAX) bits: sum with carry-in c, plus
  // group propagate/generate that are independent of c.
  function automatic cla_grp_t cla_group(input logic [BLOCK_MAX-1:0] a,
                                         input logic [BLOCK_MAX-1:0] b,
                                         input logic c, input int n);
    cla_grp_t r;
    logic     cc;
    r  = '{sum: '0, p: 1'b1, g: 1'b0};
    cc = c;
    for (int i = 0; i < BLOCK_MAX; i++) begin
      if (i < n) begin
        r.sum[i] = a[i] ^ b[i] ^ cc;
        cc       = (a[i] & b[i]) | ((a[i] ^ b[i]) & cc);
        r.g      = (a[i] & b[i]) | ((a[i] ^ b[i]) & r.g);
        r.p      = r.p & (a[i] ^ b[i]);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational slice adder: BLOCK-bit lookahead groups, group carries chained.
module cla_slice
  import adder_pkg::*;
#(
  parameter int SLICE_W = 8,
  parameter int BLOCK   = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  localparam int NG = SLICE_W / BLOCK;

  always_comb begin
    logic     c;
    cla_grp_t r;
    sum = '0;
    c   = cin;
    for (int j = 0; j < NG; j++) begin
      r = cla_group(BLOCK_MAX'(a[j*BLOCK +: BLOCK]), BLOCK_MAX'(b[j*BLOCK +: BLOCK]), c, BLOCK);
      sum[j*BLOCK +: BLOCK] = r.sum[BLOCK-1:0];
      c = r.g | (r.p & c);
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA add/subtract: one WIDTH/STAGES slice per stage, valid/ready
// stream with a single global advance.
module pipelined_cla_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int BLOCK  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SW = WIDTH / STAGES;

  if (STAGES < 1 || BLOCK < 2 || BLOCK > BLOCK_MAX || (WIDTH % (STAGES * BLOCK)) != 0) begin : g_bad_param
    $error("pipelined_cla_addsub: WIDTH must be a multiple of STAGES*BLOCK, BLOCK in 2..8");
  end

  // Operands shift right one slice per stage so the next slice always sits at
  // bit 0; finished sum bits shift in from the top. The last stage keeps its
  // operand slice unshifted so the sign bits are still available for overflow.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             sub;
    logic             cy;
  } stg_t;

  logic              advance;
  logic              accept;
  logic [STAGES-1:0] vld_pipe;
  stg_t              st_out [STAGES];
  stg_t              st_q   [STAGES];
  stg_t              fin;

  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    stg_t          s_in;
    logic [SW-1:0] s_sum;
    logic          s_cy;

    if (k == 0) begin : g_first
      assign s_in = '{a: in_a, b: in_b ^ {WIDTH{in_sub}}, sum: '0, sub: in_sub, cy: in_cin ^ in_sub};
    end else begin : g_next
      assign s_in = st_q[k-1];
    end

    cla_slice #(.SLICE_W(SW), .BLOCK(BLOCK)) u_slice (
      .a   (s_in.a[SW-1:0]),
      .b   (s_in.b[SW-1:0]),
      .cin (s_in.cy),
      .sum (s_sum),
      .cout(s_cy)
    );

    assign st_out[k] = '{
      a:   (k == STAGES-1) ? s_in.a : (s_in.a >> SW),
      b:   (k == STAGES-1) ? s_in.b : (s_in.b >> SW),
      sum: (s_in.sum >> SW) | (WIDTH'(s_sum) << (WIDTH - SW)),
      sub: s_in.sub,
      cy:  s_cy
    };
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else if (advance) begin
      vld_pipe <= STAGES'({vld_pipe, accept});
      for (int k = 0; k < STAGES; k++) st_q[k] <= st_out[k];
    end
  end

  assign fin       = st_q[STAGES-1];
  assign out_valid = vld_pipe[STAGES-1];
  assign out_sum   = out_valid ? fin.sum : '0;
  assign out_cout  = out_valid & (fin.cy ^ fin.sub);
  assign out_ovf   = out_valid & (fin.a[SW-1] == fin.b[SW-1]) & (fin.sum[WIDTH-1] != fin.a[SW-1]);
  assign out_zero  = out_valid & (fin.sum == '0);

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: directed table, stall/reset sequences and
// randomized regression for STAGES 1, 2 and 4 against an arithmetic model.
module tb_pipelined_cla_addsub;

  localparam int W    = 16;
  localparam int NOPS = 3000;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    res_t         exp;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  int   rnd_done = 0;
  logic rnd_go   = 1'b0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_sub, in_cin;
  logic         out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [W-1:0] in_a, in_b, out_sum;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(W), .STAGES(2), .BLOCK(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    int   ua, ub, sa, sb, ci, r, sr;
    res_t e;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = int'(cin);
    if (sub) begin
      r      = ua - ub - ci;
      sr     = sa - sb - ci;
      e.cout = (ua < ub + ci);
    end else begin
      r      = ua + ub + ci;
      sr     = sa + sb + ci;
      e.cout = (r > 65535);
    end
    e.sum  = r[W-1:0];
    e.ovf  = (sr > 32767) || (sr < -32768);
    e.zero = (e.sum == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corners [5];
    corners = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] out_word();
    return 64'({out_valid, out_sum, out_cout, out_ovf, out_zero});
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int S = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
    logic         iv, ir, isub, icin, ov, ordy, oc, oo, oz;
    logic [W-1:0] ia, ib, os;

    pipelined_cla_addsub #(.WIDTH(W), .STAGES(S), .BLOCK(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv), .in_ready(ir),
      .in_a(ia), .in_b(ib), .in_sub(isub), .in_cin(icin),
      .out_valid(ov), .out_ready(ordy),
      .out_sum(os), .out_cout(oc), .out_ovf(oo), .out_zero(oz)
    );

    initial begin
      res_t q[$];
      res_t e;
      int   acc;
      acc  = 0;
      iv   = 1'b0;
      ordy = 1'b1;
      ia   = '0;
      ib   = '0;
      isub = 1'b0;
      icin = 1'b0;
      wait (rnd_go);
      for (int c = 0; c < 25000 && (acc < NOPS || q.size() != 0); c++) begin
        @(posedge clk);
        #1;
        ordy = ($urandom_range(0, 3) != 0);
        if (acc < NOPS) begin
          iv   = ($urandom_range(0, 3) != 0);
          ia   = pick_operand();
          ib   = pick_operand();
          isub = 1'($urandom);
          icin = 1'($urandom);
        end else begin
          iv = 1'b0;
        end
        @(negedge clk);
        if (ov && ordy) begin
          if (q.size() == 0) begin
            check($sformatf("rnd_S%0d_extra", S), 64'(os), 64'hDEAD_BEEF);
          end else begin
            e = q.pop_front();
            check($sformatf("rnd_S%0d_result", S), 64'({os, oc, oo, oz}), 64'(e));
          end
        end
        if (iv && ir) begin
          q.push_back(model(ia, ib, isub, icin));
          acc++;
        end
      end
      check($sformatf("rnd_S%0d_accepted", S), 64'(acc), 64'(NOPS));
      check($sformatf("rnd_S%0d_drained", S), 64'(q.size()), 64'd0);
      rnd_done++;
    end
  end

  initial begin
    vec_t         tbl [8];
    res_t         sq[$];
    res_t         e;
    logic [W-1:0] ta [8];
    logic [W-1:0] tb [8];
    logic [W-1:0] held_sum;
    logic         held;
    int           sent, got, stalls;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1}};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0}};
    tbl[2] = '{16'h00FF, 16'h0F01, 1'b0, 1'b1, '{16'h1001, 1'b0, 1'b0, 1'b0}};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, '{16'hFFFE, 1'b1, 1'b0, 1'b0}};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, '{16'h7FFF, 1'b0, 1'b1, 1'b0}};
    tbl[5] = '{16'h1234, 16'h1234, 1'b1, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b1}};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0}};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b1}};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_cin    = 1'b0;
    #1;
    check("reset_outputs", out_word(), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed table: one token at a time, exact two-cycle latency.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a     = tbl[i].a;
      in_b     = tbl[i].b;
      in_sub   = tbl[i].sub;
      in_cin   = tbl[i].cin;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("tbl%0d_not_early", i), 64'(out_valid), 64'd0);
      @(negedge clk);
      check($sformatf("tbl%0d_result", i), out_word(), 64'({1'b1, tbl[i].exp}));
    end

    // Back-to-back stream with the consumer stalled for cycles 3-5.
    for (int i = 0; i < 8; i++) begin
      ta[i] = W'($urandom);
      tb[i] = W'($urandom);
    end
    sent   = 0;
    got    = 0;
    stalls = 0;
    held   = 1'b0;
    held_sum = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(posedge clk);
      #1;
      out_ready = !(c >= 3 && c <= 5);
      if (sent < 8) begin
        in_valid = 1'b1;
        in_a     = ta[sent];
        in_b     = tb[sent];
        in_sub   = 1'(sent % 2);
        in_cin   = 1'((sent / 2) % 2);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid && held) check("stall_sum_hold", 64'(out_sum), 64'(held_sum));
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 64'(in_ready), 64'd0);
        stalls++;
        held     = 1'b1;
        held_sum = out_sum;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sq.size() == 0) begin
          check("stream_extra", 64'(out_sum), 64'hDEAD_BEEF);
        end else begin
          e = sq.pop_front();
          check($sformatf("stream_res%0d", got), 64'({out_sum, out_cout, out_ovf, out_zero}), 64'(e));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sq.push_back(model(in_a, in_b, in_sub, in_cin));
        sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 64'(got), 64'd8);
    check("stream_stalled", 64'(stalls > 0), 64'd1);

    // Reset with two tokens in flight.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = 16'h1111;
    in_b     = 16'h2222;
    in_sub   = 1'b0;
    in_cin   = 1'b0;
    @(posedge clk);
    #1;
    in_a = 16'h3333;
    in_b = 16'h0001;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("flight_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_clear", out_word(), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("no_stale%0d", i), 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = 16'h4000;
    in_b     = 16'h4000;
    in_sub   = 1'b0;
    in_cin   = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_not_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("post_rst_result", out_word(), 64'({1'b1, 16'h8000, 1'b0, 1'b1, 1'b0}));

    // Randomized regression on the three side instances.
    rnd_go = 1'b1;
    fork
      wait (rnd_done == 3);
      #400000;
    join_any
    check("rnd_finished", 64'(rnd_done), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
